// File: rtl/spi_master_tx.sv
// SPI master transmit stage: frames a parallel word under active-low cs, shifts it MSB-first
// on MOSI and captures the slave's one-cycle-delayed MISO echo for a loopback check.
module spi_master_tx #(
  parameter int DATA_W  = 4,
  parameter int CLK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              send,
  input  logic              MISO,
  output logic              MOSI,
  output logic              cs,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              err
);

  localparam int BCW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_tx_sh;
  logic [DATA_W-1:0] r_tx_lat;
  logic [DATA_W-1:0] r_rx_sh;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_err;
  logic [7:0]        r_div;
  logic [BCW-1:0]    r_bit;
  logic              w_div_tc;
  logic              w_last_bit;
  logic              w_sample;

  assign w_div_tc   = (r_div == 8'(CLK_DIV - 1));
  assign w_last_bit = (r_bit == BCW'(DATA_W - 1));
  assign rx_data    = r_rx_data;
  assign err        = r_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // MISO lags MOSI by one clk, so the first cycle of each period after the first
  // (and of CAPTURE) carries the previous bit.
  always_comb begin
    w_next   = r_state;
    cs       = 1'b1;
    MOSI     = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    w_sample = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (send) w_next = SHIFT;
      end
      SHIFT: begin
        cs       = 1'b0;
        MOSI     = r_tx_sh[DATA_W-1];
        w_sample = (r_div == 8'd0) && (r_bit != '0);
        if (w_div_tc && w_last_bit) w_next = CAPTURE;
      end
      CAPTURE: begin
        w_sample = (r_div == 8'd0);
        if (w_div_tc) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_sh   <= '0;
      r_tx_lat  <= '0;
      r_rx_sh   <= '0;
      r_rx_data <= '0;
      r_err     <= 1'b0;
      r_div     <= 8'd0;
      r_bit     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_div <= 8'd0;
          r_bit <= '0;
          if (send) begin
            r_tx_sh  <= tx_data;
            r_tx_lat <= tx_data;
            r_rx_sh  <= '0;
          end
        end
        SHIFT: begin
          if (w_div_tc) begin
            r_div   <= 8'd0;
            r_tx_sh <= r_tx_sh << 1;
            r_bit   <= w_last_bit ? '0 : r_bit + 1'b1;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        CAPTURE: begin
          r_div <= w_div_tc ? 8'd0 : r_div + 8'd1;
        end
        DONE: begin
          r_rx_data <= r_rx_sh;
          r_err     <= (r_rx_sh != r_tx_lat);
        end
        default: r_div <= 8'd0;
      endcase
      if (w_sample) r_rx_sh <= {r_rx_sh[DATA_W-2:0], MISO};
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: two instances (CLK_DIV=1 and 3) behind a registered slave echo,
// compared cycle by cycle against a timing model derived from frame arithmetic.
module tb_spi_master_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int         dsel      = 0;
  logic [3:0] drv_tx    = 4'd0;
  logic       drv_send  = 1'b0;
  logic       drv_force = 1'b0;

  logic [3:0] tx1, tx3, rx1, rx3;
  logic send1, send3, miso1, miso3, mosi1, mosi3, cs1, cs3;
  logic busy1, busy3, done1, done3, err1, err3;
  logic echo1 = 1'b0;
  logic echo3 = 1'b0;

  assign tx1   = drv_tx;
  assign tx3   = drv_tx;
  assign send1 = drv_send && (dsel == 0);
  assign send3 = drv_send && (dsel == 1);
  assign miso1 = (drv_force && dsel == 0) ? 1'b1 : echo1;
  assign miso3 = (drv_force && dsel == 1) ? 1'b1 : echo3;

  // Slave model: registered echo of the (cs-gated) MOSI line.
  always @(posedge clk) begin
    echo1 <= mosi1;
    echo3 <= mosi3;
  end

  spi_master_tx #(.DATA_W(4), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(tx1), .send(send1), .MISO(miso1), .MOSI(mosi1),
    .cs(cs1), .busy(busy1), .done(done1), .rx_data(rx1), .err(err1));

  spi_master_tx #(.DATA_W(4), .CLK_DIV(3)) u_dut3 (
    .clk(clk), .rst(rst), .tx_data(tx3), .send(send3), .MISO(miso3), .MOSI(mosi3),
    .cs(cs3), .busy(busy3), .done(done3), .rx_data(rx3), .err(err3));

  logic       o_mosi, o_cs, o_busy, o_done, o_err;
  logic [3:0] o_rx;
  assign o_mosi = (dsel == 0) ? mosi1 : mosi3;
  assign o_cs   = (dsel == 0) ? cs1   : cs3;
  assign o_busy = (dsel == 0) ? busy1 : busy3;
  assign o_done = (dsel == 0) ? done1 : done3;
  assign o_err  = (dsel == 0) ? err1  : err3;
  assign o_rx   = (dsel == 0) ? rx1   : rx3;

  int n_chk  = 0;
  int n_pass = 0;

  logic       lg_mosi [64];
  logic       lg_cs   [64];
  logic       lg_busy [64];
  logic       lg_done [64];
  logic       lg_err  [64];
  logic [3:0] lg_rx   [64];

  // Reference timing, u = cycles after the acceptance cycle T0.
  function automatic int per(input int cd);
    return 5 * cd + 2;
  endfunction
  function automatic logic exp_mosi(input logic [3:0] tx, input int cd, input int u);
    if (u >= 1 && u <= 4 * cd) return tx[3 - (u - 1) / cd];
    return 1'b0;
  endfunction
  function automatic logic exp_cs(input int cd, input int u);
    return !(u >= 1 && u <= 4 * cd);
  endfunction
  function automatic logic exp_done(input int cd, input int u);
    return u == 5 * cd + 1;
  endfunction
  function automatic logic exp_busy(input int cd, input int u);
    return u >= 1 && u <= 5 * cd + 1;
  endfunction

  task automatic run(input int sel, input logic [3:0] tx_a, input logic [3:0] tx_b,
                     input logic force1, input logic hold, input int resend_at,
                     input logic [3:0] resend_tx, input int ncyc);
    int cd;
    cd        = (sel == 0) ? 1 : 3;
    dsel      = sel;
    drv_send  = 1'b0;
    drv_force = force1;
    repeat (2) @(negedge clk);
    drv_tx   = tx_a;
    drv_send = 1'b1;
    for (int t = 1; t <= ncyc; t++) begin
      @(negedge clk);
      lg_mosi[t] = o_mosi;
      lg_cs[t]   = o_cs;
      lg_busy[t] = o_busy;
      lg_done[t] = o_done;
      lg_err[t]  = o_err;
      lg_rx[t]   = o_rx;
      drv_send   = (hold && t <= per(cd)) || (t == resend_at);
      if (t == 1) drv_tx = tx_b;
      if (t == resend_at) drv_tx = resend_tx;
    end
    drv_send  = 1'b0;
    drv_force = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({cs1, mosi1, busy1, done1, rx1, err1} !== 9'b1_0_0_0_0000_0)
      $display("FAIL reset_div1 got=%b exp=100000000", {cs1, mosi1, busy1, done1, rx1, err1});
    else n_pass++;
    n_chk++;
    if ({cs3, mosi3, busy3, done3, rx3, err3} !== 9'b1_0_0_0_0000_0)
      $display("FAIL reset_div3 got=%b exp=100000000", {cs3, mosi3, busy3, done3, rx3, err3});
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single(input string name, input int sel, input logic [3:0] tx,
                             input logic force1);
    int cd, p;
    logic [3:0] erx;
    cd  = (sel == 0) ? 1 : 3;
    p   = per(cd);
    erx = force1 ? 4'hF : tx;
    run(sel, tx, ~tx, force1, 1'b0, 0, 4'd0, p);
    for (int t = 1; t <= p; t++) begin
      n_chk++;
      if (lg_mosi[t] !== exp_mosi(tx, cd, t))
        $display("FAIL %s mosi t=%0d got=%b exp=%b", name, t, lg_mosi[t], exp_mosi(tx, cd, t));
      else n_pass++;
      n_chk++;
      if ({lg_cs[t], lg_busy[t], lg_done[t]} !== {exp_cs(cd, t), exp_busy(cd, t), exp_done(cd, t)})
        $display("FAIL %s cs_busy_done t=%0d got=%b exp=%b", name, t,
                 {lg_cs[t], lg_busy[t], lg_done[t]}, {exp_cs(cd, t), exp_busy(cd, t), exp_done(cd, t)});
      else n_pass++;
    end
    n_chk++;
    if (lg_rx[p] !== erx) $display("FAIL %s rx_data got=%b exp=%b", name, lg_rx[p], erx);
    else n_pass++;
    n_chk++;
    if (lg_err[p] !== (erx != tx)) $display("FAIL %s err got=%b exp=%b", name, lg_err[p], erx != tx);
    else n_pass++;
  endtask

  task automatic test_ignore_busy();
    int p;
    p = per(1);
    run(0, 4'b0001, 4'b0001, 1'b0, 1'b0, 2, 4'b1111, p + 4);
    for (int t = 1; t <= p + 4; t++) begin
      n_chk++;
      if ({lg_mosi[t], lg_cs[t], lg_busy[t], lg_done[t]} !==
          {exp_mosi(4'b0001, 1, t), exp_cs(1, t), exp_busy(1, t), exp_done(1, t)})
        $display("FAIL ignore t=%0d got=%b exp=%b", t, {lg_mosi[t], lg_cs[t], lg_busy[t], lg_done[t]},
                 {exp_mosi(4'b0001, 1, t), exp_cs(1, t), exp_busy(1, t), exp_done(1, t)});
      else n_pass++;
    end
    n_chk++;
    if (lg_rx[p] !== 4'b0001) $display("FAIL ignore rx_data got=%b exp=0001", lg_rx[p]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    dsel     = 0;
    drv_send = 1'b0;
    repeat (2) @(negedge clk);
    drv_tx   = 4'b0110;
    drv_send = 1'b1;
    @(negedge clk);
    drv_send = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({o_cs, o_mosi, o_busy, o_done, o_rx} !== 8'b1_0_0_0_0000)
      $display("FAIL reset_mid got=%b exp=10000000", {o_cs, o_mosi, o_busy, o_done, o_rx});
    else n_pass++;
    rst = 1'b0;
    for (int t = 5; t <= 5 + per(1) + 2; t++) begin
      @(negedge clk);
      n_chk++;
      if ({o_done, o_cs} !== 2'b01) $display("FAIL reset_mid_quiet t=%0d done_cs got=%b exp=01", t, {o_done, o_cs});
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back(input int sel);
    int cd, p, u, k;
    logic [3:0] tx;
    cd = (sel == 0) ? 1 : 3;
    p  = per(cd);
    run(sel, 4'b1001, 4'b0101, 1'b0, 1'b1, 0, 4'd0, 2 * p);
    for (int t = 1; t <= 2 * p; t++) begin
      u  = ((t - 1) % p) + 1;
      k  = (t - 1) / p;
      tx = (k == 0) ? 4'b1001 : 4'b0101;
      n_chk++;
      if ({lg_mosi[t], lg_cs[t], lg_busy[t], lg_done[t]} !==
          {exp_mosi(tx, cd, u), exp_cs(cd, u), exp_busy(cd, u), exp_done(cd, u)})
        $display("FAIL b2b sel=%0d t=%0d got=%b exp=%b", sel, t, {lg_mosi[t], lg_cs[t], lg_busy[t], lg_done[t]},
                 {exp_mosi(tx, cd, u), exp_cs(cd, u), exp_busy(cd, u), exp_done(cd, u)});
      else n_pass++;
    end
    n_chk++;
    if (lg_rx[p] !== 4'b1001) $display("FAIL b2b rx0 sel=%0d got=%b exp=1001", sel, lg_rx[p]);
    else n_pass++;
    n_chk++;
    if (lg_rx[2 * p] !== 4'b0101) $display("FAIL b2b rx1 sel=%0d got=%b exp=0101", sel, lg_rx[2 * p]);
    else n_pass++;
  endtask

  task automatic test_random();
    int sel;
    logic [3:0] tx;
    logic f;
    for (int i = 0; i < 8; i++) begin
      sel = $urandom_range(0, 1);
      tx  = 4'($urandom);
      f   = ($urandom_range(0, 3) == 0);
      test_single("random", sel, tx, f);
    end
  endtask

  initial begin
    test_reset();
    test_single("basic", 0, 4'b1011, 1'b0);
    test_single("clkdiv3", 1, 4'b0110, 1'b0);
    test_single("corrupt", 0, 4'b0010, 1'b1);
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back(0);
    test_back_to_back(1);
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- Serial master stage directly upstream of the 4-bit SPI slave display block.
- Accepts a parallel word on a send request and frames it with an active-low chip-select.
- Shifts the word out MSB-first on MOSI, one bit per bit period, using the shared system clock as the shift clock.
- Captures the slave's one-cycle-delayed MISO echo back into a parallel register and flags a loopback mismatch.

Parameters:
- DATA_W, 4, frame length in bits (legal range 2..16).
- CLK_DIV, 1, clk cycles per bit period (legal range 1..255). Value 1 matches the slave's per-clk shifting.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  DATA_W  word to transmit; sampled only when a request is accepted.
- send  input  1  transfer request; level-sampled in IDLE.
- MISO  input  1  serial return from slave.
- MOSI  output  1  serial data to slave.
- cs  output  1  chip-select, active low.
- busy  output  1  high from request acceptance until the cycle after done.
- done  output  1  one-cycle pulse when the frame is complete and rx_data is valid.
- rx_data  output  DATA_W  captured return word.
- err  output  1  rx_data != latched tx word; updated with done.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE; cs=1, MOSI=0, busy=0, done=0, rx_data=0, err=0; all counters and shift registers cleared.
  - Reset mid-frame aborts: cs=1 at that same edge, no done pulse, rx_data=0.
- States: IDLE, SHIFT, CAPTURE, DONE.
- IDLE:
  - cs=1, MOSI=0.
  - On send=1: latch tx_data into tx_sh, set busy=1, go to SHIFT.
  - Acceptance cycle is T0.
- SHIFT:
  - cs=0 from T0+1.
  - MOSI=tx_sh[DATA_W-1], held for CLK_DIV cycles per bit; bits sent in order DATA_W-1 down to 0.
  - A div counter counts 0..CLK_DIV-1. On its terminal count, tx_sh shifts left (zero fill) and the bit counter increments.
  - After DATA_W periods, go to CAPTURE.
- CAPTURE:
  - Lasts one bit period (CLK_DIV cycles), cs=1, MOSI=0.
  - The slave's gated mosi is 0 here, but MISO still carries the last echoed bit for one cycle.
- MISO sampling:
  - Sample on the first cycle of bit periods 1..DATA_W-1 and on the first cycle of CAPTURE, giving DATA_W samples.
  - Shift samples into rx_sh MSB-first.
  - This captures bit i from the slave's registered echo (MISO(t)=mosi(t-1)) for any CLK_DIV.
- DONE (one cycle):
  - done=1, rx_data<=rx_sh, err<=(rx_sh!=latched tx word).
  - busy drops at the following edge; go to IDLE.
- send while busy is ignored and not queued.
- send held high continuously starts a new frame in the first IDLE cycle after DONE. Minimum gap between frames: one IDLE cycle with cs=1.
- tx_data changes after T0 do not affect the frame in flight.
- Frame latency from T0 to the done pulse: (DATA_W+1)*CLK_DIV + 1 cycles.
- cs is low for exactly DATA_W*CLK_DIV cycles per frame.
- Counter widths: div counter 8 bits; bit counter ceil(log2(DATA_W+1)) bits. No wrap occurs inside legal ranges.

Test Plan:
- Reset, then send=1 with tx_data=4'b1011, CLK_DIV=1, slave echo model:
  - cs low for 4 cycles; MOSI sequence 1,0,1,1.
  - done pulses 6 cycles after T0; rx_data=4'b1011, err=0.
- CLK_DIV=3, tx_data=4'b0110:
  - Each MOSI bit held 3 cycles; cs low for 12 cycles.
  - done pulses at T0+16; rx_data=4'b0110.
- Corrupted return: MISO forced to 1 throughout, tx_data=4'b0010 → rx_data=4'b1111, err=1.
- send re-asserted at T0+2 with tx_data=4'b1111 during a frame carrying 4'b0001:
  - The request is ignored; MOSI still shows 0,0,0,1.
  - No second frame starts until after DONE.
- rst=1 asserted at T0+3 mid-frame:
  - Next edge shows cs=1, MOSI=0, busy=0, rx_data=0.
  - No done pulse follows.
- send held high, tx_data=4'b1001 then 4'b0101:
  - Two back-to-back frames, each rx_data correct.
  - cs returns high for at least 1 IDLE cycle between frames, plus the CAPTURE period.
